// File: rtl/adder_button_sequencer.sv
// adder_button_sequencer
// Front-panel responder for the lab adder. LoadB and Run are active-low,
// asynchronous pushbuttons that are synchronised and edge-detected. A Run
// press captures operand A and starts a chunked ripple add, CHUNK bits per
// clock, into a private work register. Sum/CO are published together with a
// one-cycle Done pulse, so partial results are never visible.
module adder_button_sequencer #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             Busy,
  output logic             Done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("adder_button_sequencer: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  work;
  logic              carry;
  logic [IDXW-1:0]   idx;

  logic loadb_s1, loadb_s2, loadb_prev;
  logic run_s1, run_s2, run_prev;
  logic loadb_press, run_press;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK:0]    chunk_sum;

  // Two-flop synchronisers plus a history flop per button; idle level is 1.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      loadb_s1   <= 1'b1;
      loadb_s2   <= 1'b1;
      loadb_prev <= 1'b1;
      run_s1     <= 1'b1;
      run_s2     <= 1'b1;
      run_prev   <= 1'b1;
    end else begin
      loadb_s1   <= LoadB;
      loadb_s2   <= loadb_s1;
      loadb_prev <= loadb_s2;
      run_s1     <= Run;
      run_s2     <= run_s1;
      run_prev   <= run_s2;
    end
  end

  assign loadb_press = !loadb_s2 && loadb_prev;
  assign run_press   = !run_s2 && run_prev;

  // Select the current operand chunks and add them with the running carry.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx == IDXW'(i)) begin
        a_chunk = Aval[i*CHUNK +: CHUNK];
        b_chunk = Bval[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
  end

  // Sequencer FSM; Busy/Done are registered from the next state, so the
  // Done pulse and the Sum/CO update land on the edge that leaves DONE.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      Aval  <= '0;
      Bval  <= '0;
      Sum   <= '0;
      CO    <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      work  <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (loadb_press) begin
            Bval <= SW;
          end
          if (run_press) begin
            Aval  <= SW;
            work  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            Busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx == IDXW'(i)) begin
              work[i*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
            end
          end
          carry <= chunk_sum[CHUNK];
          if (idx == IDXW'(NCHUNK - 1)) begin
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          Sum   <= work;
          CO    <= carry;
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
